// File: rtl/hd_frame_packer_if.sv
// hd_frame_packer_if: output word stream of hd_frame_packer.
//
// Handshake: a word transfers on every rising clock edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_valid, out_data,
// out_last, out_frame_id (and out_weight when built) hold stable until that
// transfer happens. out_ready may toggle freely and has no effect unless
// out_valid is high.
//
// Signals:
//   out_valid     producer -> consumer  out_data holds a valid word
//   out_ready     consumer -> producer  consumer accepts the word
//   out_data      producer -> consumer  OUT_WIDTH codeword bits, LSB first
//   out_last      producer -> consumer  final word of a codeword
//   out_frame_id  producer -> consumer  frame offset tag of the codeword
//   out_weight    producer -> consumer  codeword Hamming weight (HD_WEIGHT_EN)
//
// Modports: master = producer (hd_frame_packer), slave = consumer.
// Optional feature macro: HD_WEIGHT_EN adds out_weight.
interface hd_frame_packer_if #(
  parameter int OUT_WIDTH = 12
) ();
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_frame_id;
`ifdef HD_WEIGHT_EN
  logic [7:0]           out_weight;

  modport master (
    output out_valid, out_data, out_last, out_frame_id, out_weight,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_data, out_last, out_frame_id, out_weight,
    output out_ready
  );
`else
  modport master (
    output out_valid, out_data, out_last, out_frame_id,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_data, out_last, out_frame_id,
    output out_ready
  );
`endif
endinterface

// File: rtl/hd_frame_packer.sv
// hd_frame_packer: gathers four hard-decision bits per beat from the DNU f0
// stage into a two-bank codeword buffer and streams each finished codeword
// as OUT_WIDTH-bit words, tagged with the frame offset sampled on beat 0.
//
// Ports:
//   read_clk            clock
//   rstn                asynchronous active-low reset
//   hd_valid            the four decision bits are a valid beat
//   hd_frame_offset     frame offset tag, sampled on beat 0 only
//   dnu0..3_hard_decision  decision bits; beat k, dnuj -> codeword bit 4k+j
//   out_if              output word stream (hd_frame_packer_if.master)
//   overflow            sticky: a whole frame was dropped (both banks full)
//   dbg_drain_state     drain FSM state (0 = IDLE, 1 = STREAM)
//
// Optional feature macro: HD_WEIGHT_EN builds a per-frame popcount that is
// presented on out_if.out_weight with every word of the frame.
module hd_frame_packer #(
  parameter int CW_LEN    = 204,
  parameter int OUT_WIDTH = 12
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic              hd_valid,
  input  logic              hd_frame_offset,
  input  logic              dnu0_hard_decision,
  input  logic              dnu1_hard_decision,
  input  logic              dnu2_hard_decision,
  input  logic              dnu3_hard_decision,
  hd_frame_packer_if.master out_if,
  output logic              overflow,
  output logic              dbg_drain_state
);
  localparam int HD_NUM = 4;
  localparam int BEATS  = CW_LEN / HD_NUM;
  localparam int WORDS  = CW_LEN / OUT_WIDTH;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW     = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} drain_state_t;

  // Fill side
  logic [CW_LEN-1:0] bank [2];
  logic [1:0]        full, full_nxt, tag;
  logic              wr_sel, rd_sel;
  logic [BW-1:0]     beat_cnt;
  logic              drop_q, offset_q;
  logic [HD_NUM-1:0] hd_bits;
  logic              beat_first, beat_last, drop_now, frame_drop, commit, cur_offset;

  // Drain side
  drain_state_t      state, state_nxt;
  logic [WW-1:0]     word_idx, word_idx_nxt, load_idx;
  logic              rd_sel_nxt, other_sel, load, load_sel, release_bank, handshake;
  logic              out_valid_q, out_valid_nxt, last_q, frame_id_q;
  logic [OUT_WIDTH-1:0] data_q;

  assign hd_bits    = {dnu3_hard_decision, dnu2_hard_decision,
                       dnu1_hard_decision, dnu0_hard_decision};
  assign beat_first = (beat_cnt == '0);
  assign beat_last  = (beat_cnt == BW'(BEATS - 1));

  // A bank being released by the drain in this very cycle counts as free.
  assign drop_now   = beat_first & full[wr_sel] & ~(release_bank & (rd_sel == wr_sel));
  // The drop decision made on beat 0 governs every later beat of the frame.
  assign frame_drop = beat_first ? drop_now : drop_q;
  assign commit     = hd_valid & beat_last & ~frame_drop;
  assign cur_offset = beat_first ? hd_frame_offset : offset_q;

  always_comb begin
    full_nxt = full;
    if (release_bank) full_nxt[rd_sel] = 1'b0;
    if (commit)       full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      wr_sel   <= 1'b0;
      full     <= '0;
      tag      <= '0;
      drop_q   <= 1'b0;
      offset_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (hd_valid) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        if (beat_first) begin
          offset_q <= hd_frame_offset;
          drop_q   <= drop_now;
          if (drop_now) overflow <= 1'b1;
        end
        if (commit) begin
          tag[wr_sel] <= cur_offset;
          wr_sel      <= ~wr_sel;
        end
      end
    end
  end

  // Frame storage carries no reset: a bank is only read once its full bit is
  // set, and reset clears every full bit.
  always_ff @(posedge read_clk) begin
    if (hd_valid && !frame_drop)
      bank[wr_sel][int'(beat_cnt)*HD_NUM +: HD_NUM] <= hd_bits;
  end

`ifdef HD_WEIGHT_EN
  // One running sum serves whichever bank is filling; it is latched into the
  // bank's weight slot on commit.
  logic [7:0] wacc, beat_pop, frame_weight, weight_q;
  logic [7:0] weight [2];

  assign beat_pop     = {7'd0, hd_bits[0]} + {7'd0, hd_bits[1]} +
                        {7'd0, hd_bits[2]} + {7'd0, hd_bits[3]};
  assign frame_weight = (beat_first ? 8'd0 : wacc) + beat_pop;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      wacc      <= 8'd0;
      weight[0] <= 8'd0;
      weight[1] <= 8'd0;
      weight_q  <= 8'd0;
    end else begin
      if (hd_valid && !frame_drop) begin
        wacc <= frame_weight;
        if (commit) weight[wr_sel] <= frame_weight;
      end
      if (load) weight_q <= weight[load_sel];
    end
  end

  assign out_if.out_weight = weight_q;
`endif

  // Drain FSM: next state and word-load control
  assign handshake = out_valid_q & out_if.out_ready;
  assign other_sel = ~rd_sel;

  always_comb begin
    state_nxt     = state;
    rd_sel_nxt    = rd_sel;
    word_idx_nxt  = word_idx;
    out_valid_nxt = out_valid_q;
    load          = 1'b0;
    load_sel      = rd_sel;
    load_idx      = word_idx;
    release_bank  = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_sel]) begin
          state_nxt     = STREAM;
          load          = 1'b1;
          load_idx      = '0;
          word_idx_nxt  = '0;
          out_valid_nxt = 1'b1;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (word_idx == WW'(WORDS - 1)) begin
            release_bank = 1'b1;
            rd_sel_nxt   = other_sel;
            word_idx_nxt = '0;
            if (full[other_sel]) begin
              // Chain straight into the other bank with no bubble.
              load     = 1'b1;
              load_sel = other_sel;
              load_idx = '0;
            end else begin
              state_nxt     = IDLE;
              out_valid_nxt = 1'b0;
            end
          end else begin
            word_idx_nxt = word_idx + 1'b1;
            load         = 1'b1;
            load_idx     = word_idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rd_sel      <= 1'b0;
      word_idx    <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      frame_id_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_sel      <= rd_sel_nxt;
      word_idx    <= word_idx_nxt;
      out_valid_q <= out_valid_nxt;
      if (load) begin
        data_q     <= bank[load_sel][int'(load_idx)*OUT_WIDTH +: OUT_WIDTH];
        last_q     <= (load_idx == WW'(WORDS - 1));
        frame_id_q <= tag[load_sel];
      end
    end
  end

  assign out_if.out_valid    = out_valid_q;
  assign out_if.out_data     = data_q;
  assign out_if.out_last     = last_q;
  assign out_if.out_frame_id = frame_id_q;
  assign dbg_drain_state     = state;
endmodule
